shift_left_seq: RTL and testbench

Multi-cycle logical left shifter for the single-cycle CPU's companion execution path, performing RV32 SLL/SLLI. It is the left-direction counterpart to the combinational arithmetic right shifter. It decomposes the shift amount bit by bit, with one log-stage per clock, so every operation has a fixed, data-independent latency. A start/busy/done handshake lets the control unit launch an operation and collect the result.

---
 rtl/shift_left_seq.sv | 76 +++++++
 tb/tb_shift_left_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/shift_left_seq.sv
// Multi-cycle logical left shifter (RV32 SLL/SLLI): one log-stage per clock,
// fixed SHAMT_W-cycle latency behind a start/busy/done handshake.
module shift_left_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done
);

  localparam int KW = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] amt;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   acc_step;

  // Stage k shifts by 2**k when the matching amount bit is set.
  always_comb begin
    // NOTE: default assignment first so no path leaves acc_step unassigned (no latch).
    acc_step = acc;
    if (amt[k]) acc_step = acc << (1 << k);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, so a partial result can
      // never leak into y after an aborted operation.
      state <= IDLE;
      acc   <= '0;
      amt   <= '0;
      k     <= '0;
      y     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            acc   <= x;
            amt   <= n[SHAMT_W-1:0];
            k     <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_step;
          k   <= k + 1'b1;
          if (k == KW'(SHAMT_W - 1)) begin
            y     <= acc_step;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_left_seq.sv
// Self-checking bench for shift_left_seq: directed and random operations,
// expected results queued at accept and compared by a decoupled monitor.
module tb_shift_left_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] x, n, y;
  logic        busy, done;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  logic [31:0] exp_q[$];
  int          acc_q[$];

  shift_left_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .n(n),
    .y(y), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops expectations on each done pulse, checks result, latency,
  // pulse width, and that y never moves outside a done edge or reset.
  logic [31:0] prev_y    = '0;
  logic        prev_done = 1'b0;
  logic        prev_rst  = 1'b1;
  always @(negedge clk) begin
    if (done) begin
      check("done_width", {31'b0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("result", y, exp_q[0]);
        check("latency", cyc - acc_q[0], 32'd5);
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
      end
    end
    if (acc_q.size() > 0 && cyc - acc_q[0] > 5) begin
      check("done_timeout", cyc - acc_q[0], 32'd5);
      void'(exp_q.pop_front());
      void'(acc_q.pop_front());
    end
    if (!done && !rst && !prev_rst) check("y_stable", y, prev_y);
    prev_y    = y;
    prev_done = done;
    prev_rst  = rst;
  end

  // Issue one operation at the current negedge; returns on the negedge after
  // the expected done edge. hold keeps start high for back-to-back issue,
  // poke pulses start with junk operands mid-run.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input bit hold, input bit poke);
    start = 1'b1;
    x = a;
    n = b;
    @(negedge clk);
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    for (int j = 0; j < 5; j++) begin
      check("busy_run", {31'b0, busy}, 32'd1);
      start = hold || (poke && j == 1);
      x = $urandom;
      n = $urandom;
      @(negedge clk);
    end
    check("busy_done", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          h;
    rst = 1'b1; start = 1'b0; x = '0; n = '0;
    repeat (2) @(negedge clk);
    check("rst_y", y, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with hand-derived results.
    run_op(32'h100F0888, 32'h0000001B, 32'h40000000, 1'b0, 1'b0);
    run_op(32'h100F0888, 32'h0010001B, 32'h40000000, 1'b0, 1'b0);
    run_op(32'hF10F0888, 32'h0000001B, 32'h40000000, 1'b0, 1'b0);
    run_op(32'hF10F0888, 32'h0010001B, 32'h40000000, 1'b0, 1'b0);
    run_op(32'h00000001, 32'd31,       32'h80000000, 1'b0, 1'b0);
    run_op(32'h12345678, 32'd0,        32'h12345678, 1'b0, 1'b0);
    run_op(32'h12345678, 32'd4,        32'h23456780, 1'b0, 1'b0);
    run_op(32'hA5A5A5A5, 32'd8,        32'hA5A5A500, 1'b0, 1'b1);
    // Back-to-back with start held high: period of 6 cycles.
    run_op(32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 1'b1, 1'b0);
    run_op(32'h0000BEEF, 32'd16,       32'hBEEF0000, 1'b1, 1'b0);
    run_op(32'h80000001, 32'hFFFFFFE1, 32'h00000002, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Reset mid-operation: rst sampled at accept edge + 3.
    start = 1'b1; x = 32'h0000F00D; n = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_y", y, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_op(32'h00000003, 32'd30, 32'hC0000000, 1'b0, 1'b0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      h  = (i != 999) && ($urandom_range(0, 3) == 0);
      run_op(ra, rb, ra << rb[4:0], h, ($urandom_range(0, 7) == 0));
      if (!h && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    start = 1'b0;
    repeat (10) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
